// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared constants and helpers for the serial pattern detector
package seq_detector_pkg;
    localparam int SEQ_PAT_W_MIN = 2;
    localparam int SEQ_PAT_W_MAX = 32;
    localparam logic [2:0] SEQ_DEFAULT_PATTERN = 3'b110;
    function automatic int seq_fill_width(input int pat_width);
        return $clog2(pat_width);
    endfunction
endpackage

// File: rtl/seq_history.sv
// seq_history: accepted-bit history, fill level and current pattern of the detector
// Ports: clk, rst (async, active-high); en/b accepted bit; pat_load/pat_in pattern reload;
//        match (same-cycle detection from the top); hist last PAT_WIDTH-1 bits (LSB newest);
//        pat current pattern; window_full set once PAT_WIDTH-1 bits are held.
module seq_history
    import seq_detector_pkg::*;
#(
    parameter int PAT_WIDTH = 3,
    parameter logic [PAT_WIDTH-1:0] PATTERN = PAT_WIDTH'(SEQ_DEFAULT_PATTERN),
    parameter int OVERLAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 b,
    input  logic                 pat_load,
    input  logic [PAT_WIDTH-1:0] pat_in,
    input  logic                 match,
    output logic [PAT_WIDTH-2:0] hist,
    output logic [PAT_WIDTH-1:0] pat,
    output logic                 window_full
);
    localparam int FW = seq_fill_width(PAT_WIDTH);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_WIDTH - 1);
    logic [PAT_WIDTH-2:0] hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [PAT_WIDTH-1:0] pat_q, pat_d;
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = (PAT_WIDTH-1)'({hist_q, b});
            // non-overlapping mode restarts the window so the next match needs fresh bits
            fill_d = (match && OVERLAP == 0) ? '0 : (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end
    assign hist        = hist_q;
    assign pat         = pat_q;
    assign window_full = fill_q == FILL_MAX;
endmodule

// File: rtl/seq_detector.sv
// seq_detector: parametrised serial bit-pattern detector with same-cycle Mealy match
// Ports: clk, rst (async, active-high); en qualifies b; b serial bit (MSB of pattern oldest);
//        pat_load/pat_in reload pattern and clear fill/count; d combinational match;
//        match_count saturating match counter.
// Build option: define SEQ_DETECTOR_COUNT_EN to build the match counter, otherwise it reads 0.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int PAT_WIDTH = 3,
    parameter logic [PAT_WIDTH-1:0] PATTERN = PAT_WIDTH'(SEQ_DEFAULT_PATTERN),
    parameter int OVERLAP = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 b,
    input  logic                 pat_load,
    input  logic [PAT_WIDTH-1:0] pat_in,
    output logic                 d,
    output logic [CNT_WIDTH-1:0] match_count
);
    logic [PAT_WIDTH-2:0] hist;
    logic [PAT_WIDTH-1:0] pat;
    logic window_full;
    seq_history #(
        .PAT_WIDTH(PAT_WIDTH),
        .PATTERN  (PATTERN),
        .OVERLAP  (OVERLAP)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .b          (b),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .match      (d),
        .hist       (hist),
        .pat        (pat),
        .window_full(window_full)
    );
    assign d = en && !pat_load && window_full && ({hist, b} == pat);
`ifdef SEQ_DETECTOR_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = pat_load ? '0 : (d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif
endmodule
